// File: rtl/hash_core_arbiter_if.sv
// Requester-side and core-side handshake bundle for the shared hash core arbiter.
// The arbiter connects through the slave modport; the requesters and the core use master.
interface hash_core_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 1088,
    parameter int DIG_W  = 256
);
    logic [N_REQ-1:0]        req_start;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_end;
    logic [N_REQ*DIG_W-1:0]  req_digest;
    logic                    core_start;
    logic [DATA_W-1:0]       core_data;
    logic                    core_end;
    logic [DIG_W-1:0]        core_digest;
    logic [2:0]              grant_id;
    logic                    busy;

    modport master (
        output req_start, req_data, core_end, core_digest,
        input  req_end, req_digest, core_start, core_data, grant_id, busy
    );

    modport slave (
        input  req_start, req_data, core_end, core_digest,
        output req_end, req_digest, core_start, core_data, grant_id, busy
    );
endinterface

// File: rtl/hash_core_arbiter.sv
// Round-robin sequencer that shares one hash core among N_REQ requesters.
// Each digest is kept in a per-requester register until that requester completes again.
module hash_core_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 1088,
    parameter int DIG_W  = 256
) (
    input  logic               clk,
    input  logic               reset,
    hash_core_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | searching upward from ptr for an eligible requester
    // ISSUE | core_start high, waiting for core_end
    // DONE  | waiting for core_end low, and for req_start low unless aborted
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             ptr, ptr_nxt, grant_id, pick;
    logic [3:0]             cand;
    logic [7:0]             eligible, start_w;
    logic                   abort, found, start_g;
    logic                   grant_go, release_go;
    logic                   core_start_c, busy_c;
    logic [N_REQ-1:0]       req_end;
    logic [N_REQ*DIG_W-1:0] req_digest;
    logic [DATA_W-1:0]      core_data, data_pick;

    // Pad to 8 so a 3-bit index is always in range regardless of N_REQ.
    assign start_w  = 8'(bus.req_start);
    assign eligible = 8'(bus.req_start & ~req_end);
    assign start_g  = start_w[grant_id];
    assign ptr_nxt  = (grant_id == 3'(N_REQ - 1)) ? 3'd0 : grant_id + 3'd1;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
            if (!found && eligible[cand[2:0]]) begin
                found = 1'b1;
                pick  = cand[2:0];
            end
        end
    end

    always_comb begin
        data_pick = '0;
        for (int i = 0; i < N_REQ; i++)
            if (3'(i) == pick) data_pick = bus.req_data[i*DATA_W +: DATA_W];
    end

    // Holding off while core_end is still high keeps core_start from overlapping it.
    assign grant_go   = (state == IDLE) && found && !bus.core_end;
    assign release_go = (state == DONE) && !bus.core_end && (abort || !start_g);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_go)     state_nxt = ISSUE;
            ISSUE:   if (bus.core_end) state_nxt = DONE;
            DONE:    if (release_go)   state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_start_c = (state == ISSUE);
        busy_c       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            grant_id   <= '0;
            abort      <= 1'b0;
            core_data  <= '0;
            req_end    <= '0;
            req_digest <= '0;
        end else begin
            if (grant_go) begin
                grant_id  <= pick;
                core_data <= data_pick;
                abort     <= 1'b0;
            end
            // The core cannot be cancelled, so an abort only suppresses the result.
            if (state == ISSUE) begin
                if (!start_g) abort <= 1'b1;
                if (bus.core_end && !abort) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (3'(i) == grant_id) begin
                            req_digest[i*DIG_W +: DIG_W] <= bus.core_digest;
                            req_end[i]                   <= 1'b1;
                        end
                    end
                end
            end
            if (release_go) begin
                ptr <= ptr_nxt;
                for (int i = 0; i < N_REQ; i++)
                    if (3'(i) == grant_id) req_end[i] <= 1'b0;
            end
        end
    end

    assign bus.req_end    = req_end;
    assign bus.req_digest = req_digest;
    assign bus.core_data  = core_data;
    assign bus.grant_id   = grant_id;
    assign bus.core_start = core_start_c;
    assign bus.busy       = busy_c;
endmodule

// File: tb/tb_hash_core_arbiter.sv
// Bench for hash_core_arbiter: behavioural core, requesters that drop on req_end,
// grant/completion scoreboard queues, a vector table and hand-written corner sequences.
module tb_hash_core_arbiter;
    localparam int N        = 4;
    localparam int DW       = 1088;
    localparam int GW       = 256;
    localparam int CORE_LAT = 10;

    typedef struct {
        int              id;
        logic [GW-1:0]   dig;
    } done_t;

    typedef struct {
        logic [N-1:0] mask;
        int           hold;
        int           n;
        int           order [4];
    } vec_t;

    logic clk;
    logic reset;

    hash_core_arbiter_if #(.N_REQ(N), .DATA_W(DW), .DIG_W(GW)) bus ();

    hash_core_arbiter #(.N_REQ(N), .DATA_W(DW), .DIG_W(GW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int            checks;
    int            failures;
    int            cyc;
    int            end_fall_cyc;
    int            extra_hold;
    int            lat_cnt;
    int            hold_cnt;
    int            tag   [N];
    int            rereq [N];
    logic [GW-1:0] last_dig [N];
    logic [N-1:0]  re_q;
    logic [N-1:0]  seen_end;
    logic          cs_q;
    logic          ce_q;
    bit            auto_drop;
    int            exp_grant [$];
    done_t         exp_done  [$];
    vec_t          vecs [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] blk_of(int id, int t);
        logic [DW-1:0] b;
        b = '0;
        for (int w = 0; w < DW/32; w++)
            b[w*32 +: 32] = (32'(id) << 24) ^ (32'(t) << 12) ^ (32'(w) * 32'h9e37_79b1);
        return b;
    endfunction

    function automatic logic [GW-1:0] dig_of(logic [DW-1:0] d);
        return d[GW-1:0] ^ (d[2*GW-1:GW] << 3) ^ d[DW-1 -: GW] ^ {(GW/32){32'hc3a5_0f1e}};
    endfunction

    // Behavioural hash core: replies after CORE_LAT cycles of core_start,
    // then holds core_end for extra_hold cycles after core_start falls.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.core_end    <= 1'b0;
            bus.core_digest <= '0;
            lat_cnt         <= 0;
            hold_cnt        <= 0;
        end else if (bus.core_end) begin
            if (!bus.core_start) begin
                if (hold_cnt >= extra_hold) begin
                    bus.core_end <= 1'b0;
                    hold_cnt     <= 0;
                end else begin
                    hold_cnt <= hold_cnt + 1;
                end
            end
        end else if (bus.core_start) begin
            if (lat_cnt == CORE_LAT - 1) begin
                bus.core_end    <= 1'b1;
                bus.core_digest <= dig_of(bus.core_data);
                lat_cnt         <= 0;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    function automatic void chk(string name, logic [GW-1:0] act, logic [GW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic vec_t mk(logic [N-1:0] mask, int hold, int n, int o0, int o1, int o2, int o3);
        vec_t v;
        v.mask  = mask;
        v.hold  = hold;
        v.n     = n;
        v.order[0] = o0;
        v.order[1] = o1;
        v.order[2] = o2;
        v.order[3] = o3;
        return v;
    endfunction

    task automatic raise(int i);
        tag[i]++;
        bus.req_data[i*DW +: DW] = blk_of(i, tag[i]);
        bus.req_start[i] = 1'b1;
    endtask

    task automatic push(int id, int t, bit completes);
        done_t e;
        exp_grant.push_back(id);
        if (completes) begin
            e.id  = id;
            e.dig = dig_of(blk_of(id, t));
            exp_done.push_back(e);
            last_dig[id] = e.dig;
        end
    endtask

    task automatic start_seq();
        end_fall_cyc = -1;
        seen_end     = '0;
    endtask

    // One clock, sampled on the falling edge; checks grants and completions as they appear.
    task automatic tick();
        int    g;
        done_t e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus.core_start && !cs_q) begin
            chk("core_start_while_core_end", 256'(bus.core_end), 256'(0));
            chk("grant_expected", 256'(exp_grant.size() != 0), 256'(1));
            if (exp_grant.size() != 0) begin
                g = exp_grant.pop_front();
                chk("grant_id", 256'(bus.grant_id), 256'(g));
                chk("core_data", 256'(bus.core_data == blk_of(g, tag[g])), 256'(1));
            end
            if (end_fall_cyc >= 0) begin
                chk("release_gap", 256'(cyc - end_fall_cyc), 256'(2));
                end_fall_cyc = -1;
            end
        end
        if (!bus.core_end && ce_q) end_fall_cyc = cyc;
        for (int i = 0; i < N; i++) begin
            if (bus.req_end[i] && !re_q[i]) begin
                seen_end[i] = 1'b1;
                chk("done_expected", 256'(exp_done.size() != 0), 256'(1));
                if (exp_done.size() != 0) begin
                    e = exp_done.pop_front();
                    chk("done_id", 256'(i), 256'(e.id));
                    chk("digest", bus.req_digest[i*GW +: GW], e.dig);
                end
                if (auto_drop) bus.req_start[i] = 1'b0;
            end else if (!bus.req_end[i] && re_q[i] && rereq[i] > 0) begin
                rereq[i]--;
                raise(i);
            end
        end
        re_q = bus.req_end;
        cs_q = bus.core_start;
        ce_q = bus.core_end;
    endtask

    task automatic run_idle(int budget);
        int n;
        n = 0;
        while ((exp_grant.size() != 0 || exp_done.size() != 0 || bus.busy || bus.req_start != '0)
               && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 256'(n < budget), 256'(1));
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!bus.core_start && n < 30) begin
            tick();
            n++;
        end
        chk("grant_timeout", 256'(n < 30), 256'(1));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_grant.delete();
        exp_done.delete();
        bus.req_start = '0;
        for (int i = 0; i < N; i++) begin
            rereq[i]    = 0;
            last_dig[i] = '0;
        end
        tick();
        tick();
        reset = 1'b1;
        start_seq();
    endtask

    task automatic apply_row(vec_t v);
        start_seq();
        extra_hold = v.hold;
        for (int i = 0; i < N; i++)
            if (v.mask[i]) raise(i);
        for (int k = 0; k < v.n; k++)
            push(v.order[k], tag[v.order[k]], 1'b1);
        run_idle(300);
        extra_hold = 0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        end_fall_cyc  = -1;
        extra_hold    = 0;
        auto_drop     = 1'b1;
        re_q          = '0;
        seen_end      = '0;
        cs_q          = 1'b0;
        ce_q          = 1'b0;
        reset         = 1'b1;
        bus.req_start = '0;
        bus.req_data  = '0;
        for (int i = 0; i < N; i++) begin
            tag[i]      = 0;
            rereq[i]    = 0;
            last_dig[i] = '0;
        end

        // Grant orders derived by hand from the round-robin pointer carried row to row.
        vecs[0] = mk(4'b1111, 0, 4, 0, 1, 2, 3);
        vecs[1] = mk(4'b0101, 0, 2, 0, 2, 0, 0);
        vecs[2] = mk(4'b0011, 0, 2, 0, 1, 0, 0);
        vecs[3] = mk(4'b1010, 0, 2, 3, 1, 0, 0);
        vecs[4] = mk(4'b0110, 0, 2, 2, 1, 0, 0);
        vecs[5] = mk(4'b1001, 0, 2, 3, 0, 0, 0);

        #1;
        do_reset();
        chk("rst_req_end", 256'(bus.req_end), 256'(0));
        chk("rst_digest", 256'(bus.req_digest != '0), 256'(0));
        chk("rst_core_start", 256'(bus.core_start), 256'(0));
        chk("rst_core_data", 256'(bus.core_data != '0), 256'(0));
        chk("rst_grant_id", 256'(bus.grant_id), 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));

        // Single request with exact cycle positions.
        start_seq();
        auto_drop = 1'b0;
        raise(0);
        push(0, tag[0], 1'b1);
        chk("single_start_c0", 256'(bus.core_start), 256'(0));
        tick();
        chk("single_start_c1", 256'(bus.core_start), 256'(1));
        chk("single_busy_c1", 256'(bus.busy), 256'(1));
        for (int t = 2; t <= 11; t++) tick();
        chk("single_end_c11", 256'(bus.req_end[0]), 256'(0));
        tick();
        chk("single_end_c12", 256'(bus.req_end[0]), 256'(1));
        chk("single_start_c12", 256'(bus.core_start), 256'(0));
        tick();
        chk("single_end_held", 256'(bus.req_end[0]), 256'(1));
        bus.req_start[0] = 1'b0;
        tick();
        chk("single_end_clear", 256'(bus.req_end[0]), 256'(0));
        chk("single_idle", 256'(bus.busy), 256'(0));
        auto_drop = 1'b1;

        // Contention table, starting from ptr=0.
        do_reset();
        for (int r = 0; r < 6; r++) apply_row(vecs[r]);

        // Fairness: 1 re-requests at once, yet pending 3 goes first (ptr=1 here).
        start_seq();
        rereq[1] = 1;
        raise(1);
        raise(3);
        push(1, tag[1], 1'b1);
        push(3, tag[3], 1'b1);
        push(1, tag[1] + 1, 1'b1);
        run_idle(300);

        // Abort: 2 drops mid-ISSUE, 3 follows once core_end falls (ptr=2 here).
        start_seq();
        raise(2);
        raise(3);
        push(2, tag[2], 1'b0);
        push(3, tag[3], 1'b1);
        wait_start();
        tick();
        tick();
        tick();
        bus.req_start[2] = 1'b0;
        run_idle(300);
        chk("abort_no_end", 256'(seen_end[2]), 256'(0));
        chk("abort_digest_kept", bus.req_digest[2*GW +: GW], last_dig[2]);

        // Slow core release: core_end held 3 extra cycles (ptr=0 here).
        apply_row(mk(4'b0101, 3, 2, 0, 2, 0, 0));

        // Reset while ISSUE is active, then a fresh request.
        start_seq();
        raise(3);
        push(3, tag[3], 1'b1);
        wait_start();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_req_end", 256'(bus.req_end), 256'(0));
        for (int i = 0; i < N; i++)
            chk("midrst_digest", bus.req_digest[i*GW +: GW], 256'(0));
        chk("midrst_core_start", 256'(bus.core_start), 256'(0));
        chk("midrst_core_data", 256'(bus.core_data != '0), 256'(0));
        chk("midrst_grant_id", 256'(bus.grant_id), 256'(0));
        chk("midrst_busy", 256'(bus.busy), 256'(0));
        do_reset();
        apply_row(mk(4'b0010, 0, 1, 1, 0, 0, 0));
        chk("post_rst_slot0", bus.req_digest[0 +: GW], 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hash_core_arbiter.md
# hash_core_arbiter

Round-robin arbiter and sequencer that shares one hash core (SHA3-class, one-block absorb plus digest) among up to `N_REQ` hash requesters, such as the Cn, Csn, Cv and C_star hash units of the verify path. Each requester uses the codebase's level start/end handshake. The arbiter grants one requester at a time and drives the core with the same handshake. It latches each requester's digest into a dedicated result register and returns completion through that requester's `req_end`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 1088: message block width presented to the core.
- `DIG_W`, 256: digest width.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_start`  in  `N_REQ`  level request per requester; held high until that requester's `req_end` is seen.
- `req_data`  in  `N_REQ*DATA_W`  message blocks; requester i occupies bits `[i*DATA_W +: DATA_W]`; must be stable while `req_start[i]` is high.
- `req_end`  out  `N_REQ`  completion per requester; held high until `req_start[i]` falls.
- `req_digest`  out  `N_REQ*DIG_W`  per-requester result registers; requester i occupies `[i*DIG_W +: DIG_W]`.
- `core_start`  out  1  level start to the shared core.
- `core_data`  out  `DATA_W`  registered copy of the granted requester's block.
- `core_end`  in  1  core done; the core holds it high until `core_start` falls.
- `core_digest`  in  `DIG_W`  valid while `core_end` is high.
- `grant_id`  out  3  index of the current or last grant.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, ISSUE, DONE.
- **Eligibility:** requester i is eligible when `req_start[i]`=1 and `req_end[i]`=0.
- **IDLE:**
  - Search from `ptr` upward, modulo `N_REQ`, for the first eligible requester g.
  - If one is found: latch `grant_id`=g, latch `core_data`=`req_data[g]`, clear `abort`, and go to ISSUE.
- **ISSUE:**
  - `core_start`=1.
  - If `req_start[g]` falls, set `abort`=1. The core transaction still runs to completion because the core has no cancel.
  - On `core_end`=1: set `core_start`=0.
    - If `abort`=0: write `req_digest[g]`=`core_digest` and set `req_end[g]`=1.
    - Go to DONE in either case.
- **DONE:**
  - Wait until `core_end`=0. If `abort`=0, also wait until `req_start[g]`=0.
  - Then clear `req_end[g]`, set `ptr`=(g+1) mod `N_REQ`, and go to IDLE.
- **Digest retention:** `req_digest[i]` holds its value until requester i completes again. It is never cleared except by reset.
- **Core handshake:** `core_start` is never asserted while `core_end` is high.
- **Starvation bound:** a continuously requesting requester is granted within `N_REQ`-1 other transactions.

## Timing
- **Reset values:** `req_end`=0, `req_digest`=0, `core_start`=0, `core_data`=0, `grant_id`=0, `busy`=0, `ptr`=0, `abort`=0, state=IDLE. Reset applies immediately and asynchronously, including mid-transaction. The core must be reset by the same signal.
- **Grant latency:** `req_start[g]` sampled high in IDLE at cycle 0 gives ISSUE with `core_start`=1 and valid `core_data` from cycle 1.
- **Completion:** `core_end` sampled high at cycle k gives `req_end[g]`=1, `req_digest[g]` valid and `core_start`=0 at cycle k+1.
- **Release:** `req_start[g]`=0 and `core_end`=0 sampled at cycle m give `req_end[g]`=0 and IDLE at cycle m+1. A new grant is possible with `core_start` high at m+2.
- **Simultaneous requests:** the lowest index at or after `ptr` wins. Requests that are not granted are held and serviced later; none are lost.
- **Start after end:** a requester that raises `req_start` while its own `req_end` is still high is ignored until `req_end` clears.
- **Abort:** a requester that drops `req_start` during ISSUE sees no `req_end` and no digest update. The arbiter releases within 1 cycle after `core_end` falls.

## Test plan
- **Single request:** reset, then `req_start`=0001 with `req_data[0]`=block A; model core replies after 10 cycles with digest D. Expect:
  - `core_start` high at cycle 1.
  - `req_end[0]` at cycle 12 and `req_digest[0]`=D.
  - `req_end[0]` clears 1 cycle after `req_start[0]` falls.
- **Full contention:** all four `req_start`=1111 at once. Expect grants in order 0,1,2,3. Then raise 0 and 2 again with `ptr`=0: order 0,2. Every digest lands in the correct slot.
- **Fairness:** requester 1 re-requests immediately after each completion while 3 is pending. Expect 3 to be granted before 1's second grant.
- **Abort:** requester 2 drops `req_start` mid-ISSUE. Expect:
  - `req_end[2]` stays 0.
  - `req_digest[2]` keeps its old value.
  - Next grant goes to 3 after `core_end` falls.
- **Reset mid-ISSUE:** assert `reset`=0 while `core_start`=1. Expect all outputs at reset values the same cycle. After release, a fresh request completes normally.
- **Slow core release:** the core holds `core_end` 3 extra cycles after `core_start` falls. Expect no new `core_start` until `core_end`=0.
